// File: rtl/adder_clk_pkg.sv
// adder_clk_pkg: shared defaults and channel-select width helper for the adder clock divider
package adder_clk_pkg;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_HALF = 10;
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adder_clk_div_if.sv
// adder_clk_div_if: runtime half-period configuration port (valid/ready)
interface adder_clk_div_if import adder_clk_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int CH_W = 1
);
  logic cfg_valid;
  logic cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  modport master(output cfg_valid, cfg_ch, cfg_half, input cfg_ready);
  modport slave(input cfg_valid, cfg_ch, cfg_half, output cfg_ready);
endinterface

// File: rtl/adder_clk_chan.sv
// adder_clk_chan: one divider channel with half-period counter and deferred ratio update
module adder_clk_chan import adder_clk_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic resync,
  input  logic load,
  input  logic [CNT_W-1:0] load_half,
  output logic pending,
  output logic div_clk,
  output logic tick
);
  logic [CNT_W-1:0] cnt, half, pend_half;
  logic wrap;
  assign wrap = cnt == half;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      half <= CNT_W'(DEFAULT_HALF);
      pend_half <= CNT_W'(DEFAULT_HALF);
      pending <= 1'b0;
      div_clk <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (resync || (en && wrap)) begin
        cnt <= '0;
        if (pending) half <= pend_half;
        pending <= 1'b0;
        div_clk <= resync ? 1'b0 : ~div_clk;
        tick <= !resync && !div_clk;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
      // a load is only possible while not pending, so it never collides with an apply
      if (load) begin
        pend_half <= load_half;
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_clk_div.sv
// adder_clk_div: multi-channel programmable clock divider producing divided levels and rising-edge ticks
module adder_clk_div import adder_clk_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_HALF,
  parameter int CH_W = ch_width(NUM_CH)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic resync,
  adder_clk_div_if.slave cfg,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick
);
  logic [NUM_CH-1:0] pending, load;
  // out-of-range channels always report ready so their writes are silently dropped
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg.cfg_ch == CH_W'(i)) cfg.cfg_ready = ~pending[i];
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign load[c] = cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_ch == CH_W'(c);
    adder_clk_chan #(.CNT_W(CNT_W), .DEFAULT_HALF(DEFAULT_HALF)) u_chan (
      .clk(clk),
      .reset(reset),
      .en(en),
      .resync(resync),
      .load(load[c]),
      .load_half(cfg.cfg_half),
      .pending(pending[c]),
      .div_clk(div_clk[c]),
      .tick(tick[c])
    );
  end
endmodule

// File: tb/tb_adder_clk_div.sv
// tb_adder_clk_div: directed self-checking bench for the multi-channel clock divider
module tb_adder_clk_div;
  import adder_clk_pkg::*;
  localparam int NCH = 3;
  localparam int CW = 8;
  localparam int CHW = 2;
  typedef struct {int ch; int h; int first; int hi; int lo;} vec_t;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, resync = 1'b0;
  logic [NCH-1:0] div_clk, tick;
  int tests = 0, fails = 0;
  int ft[NCH];
  int n, hi, lo, tk, tk2, r;
  vec_t vecs[5];

  adder_clk_div_if #(.CNT_W(CW), .CH_W(CHW)) cfg();
  adder_clk_div #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(10), .CH_W(CHW)) dut (
    .clk(clk), .reset(reset), .en(en), .resync(resync), .cfg(cfg),
    .div_clk(div_clk), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ready_of(input int ch, output int rd);
    cfg.cfg_ch = CHW'(ch);
    #1;
    rd = int'(cfg.cfg_ready);
  endtask

  task automatic cfg_write(input int ch, input int h);
    cfg.cfg_ch = CHW'(ch);
    cfg.cfg_half = CW'(h);
    cfg.cfg_valid = 1'b1;
    step();
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    step();
    resync = 1'b0;
  endtask

  task automatic run_level(input int ch, input logic lv, output int cnt, output int ticks);
    cnt = 0;
    ticks = 0;
    while (div_clk[ch] == lv && cnt < 600) begin
      cnt++;
      ticks += int'(tick[ch]);
      step();
    end
  endtask

  task automatic wait_tick(input int ch, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick[ch] && cnt < 600);
  endtask

  task automatic first_ticks();
    for (int c = 0; c < NCH; c++) ft[c] = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      for (int c = 0; c < NCH; c++) if (tick[c] && ft[c] == 0) ft[c] = i;
    end
  endtask

  initial begin
    vecs[0] = '{ch: 0, h: 255, first: 256, hi: 256, lo: 256};
    vecs[1] = '{ch: 1, h: 0, first: 1, hi: 1, lo: 1};
    vecs[2] = '{ch: 0, h: 1, first: 2, hi: 2, lo: 2};
    vecs[3] = '{ch: 1, h: 3, first: 4, hi: 4, lo: 4};
    vecs[4] = '{ch: 0, h: 10, first: 11, hi: 11, lo: 11};
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch = '0;
    cfg.cfg_half = '0;
    repeat (3) step();
    check("rst_div_clk", int'(div_clk), 0);
    check("rst_tick", int'(tick), 0);
    ready_of(0, r);
    check("rst_ready", r, 1);
    en = 1'b1;
    reset = 1'b0;
    // defaults: first rise 11 cycles after release, 50% duty, period 22
    wait_tick(0, n);
    check("default_first_rise", n, 11);
    check("ch1_same_phase", int'(div_clk[1]), 1);
    run_level(0, 1'b1, hi, tk);
    run_level(0, 1'b0, lo, tk2);
    check("default_high", hi, 11);
    check("default_low", lo, 11);
    check("default_ticks_per_period", tk + tk2, 1);
    // ratio change mid half-period completes the old half first
    repeat (3) step();
    cfg_write(1, 3);
    ready_of(1, r);
    check("busy_after_accept", r, 0);
    run_level(1, 1'b1, n, tk);
    check("old_half_finishes", n, 7);
    ready_of(1, r);
    check("ready_after_apply", r, 1);
    run_level(1, 1'b0, lo, tk);
    run_level(1, 1'b1, hi, tk);
    check("new_low", lo, 4);
    check("new_high", hi, 4);
    check("new_tick_once", tk, 1);
    // enable hold stretches the count; config during hold applied afterwards
    pulse_resync();
    check("resync_clears", int'(div_clk), 0);
    repeat (3) step();
    en = 1'b0;
    cfg_write(0, 2);
    tk = $countones(tick);
    repeat (4) begin
      step();
      tk += $countones(tick);
    end
    check("no_tick_in_hold", tk, 0);
    ready_of(0, r);
    check("hold_cfg_pending", r, 0);
    en = 1'b1;
    wait_tick(0, n);
    check("hold_stretch", n, 8);
    run_level(0, 1'b1, hi, tk);
    check("hold_cfg_applied", hi, 3);
    // resync applies pending values immediately
    cfg_write(0, 10);
    cfg_write(1, 4);
    pulse_resync();
    check("resync_div_low", int'(div_clk), 0);
    ready_of(0, r);
    check("resync_apply_ch0", r, 1);
    ready_of(1, r);
    check("resync_apply_ch1", r, 1);
    first_ticks();
    check("resync_ch1_rise", ft[1], 5);
    check("resync_ch0_rise", ft[0], 11);
    for (int v = 0; v < 5; v++) begin
      cfg_write(vecs[v].ch, vecs[v].h);
      pulse_resync();
      wait_tick(vecs[v].ch, n);
      check($sformatf("vec%0d_first", v), n, vecs[v].first);
      run_level(vecs[v].ch, 1'b1, hi, tk);
      run_level(vecs[v].ch, 1'b0, lo, tk2);
      check($sformatf("vec%0d_high", v), hi, vecs[v].hi);
      check($sformatf("vec%0d_low", v), lo, vecs[v].lo);
      check($sformatf("vec%0d_ticks", v), tk + tk2, 1);
    end
    // out-of-range channel: accepted and dropped
    ready_of(3, r);
    check("oor_ready", r, 1);
    cfg_write(3, 0);
    for (int c = 0; c < NCH; c++) begin
      ready_of(c, r);
      check($sformatf("oor_no_pending_ch%0d", c), r, 1);
    end
    pulse_resync();
    first_ticks();
    check("oor_ch0", ft[0], 11);
    check("oor_ch1", ft[1], 4);
    check("oor_ch2", ft[2], 11);
    // reset discards pending config and restores defaults
    cfg_write(1, 5);
    ready_of(1, r);
    check("pre_reset_pending", r, 0);
    reset = 1'b1;
    step();
    check("reset_div_low", int'(div_clk), 0);
    check("reset_tick_low", int'(tick), 0);
    step();
    reset = 1'b0;
    ready_of(1, r);
    check("post_reset_ready", r, 1);
    first_ticks();
    check("post_reset_ch0", ft[0], 11);
    check("post_reset_ch1", ft[1], 11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
